// File: rtl/tpu_pkg.sv
// Constants and types shared by the instruction streamer and the control unit.
// Opcode and burst depth must match on both sides of the fetch port.
package tpu_pkg;

    localparam logic [7:0] OP_NO_OP       = 8'h00;
    localparam int         TPU_PROG_DEPTH = 10;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        ARM    = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } stream_state_t;

endpackage

// File: rtl/instr_buffer.sv
// Instruction byte storage: one synchronous write port, one combinational read port.
// No reset on the array; the loaded count qualifies which entries are meaningful.
module instr_buffer #(
    parameter int DEPTH  = 10,
    parameter int DATA_W = 8,
    parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Addresses past the last entry read as zero rather than out of bounds.
    assign rd_data = ({1'b0, rd_addr} < (AW+1)'(DEPTH)) ? mem[rd_addr] : '0;

endmodule

// File: rtl/instruction_streamer.sv
// Buffers a program from the host, then bursts it to the control unit's ui_in
// after a one-cycle fetch_ins strobe. One burst per reset.
module instruction_streamer
    import tpu_pkg::*;
#(
    parameter int PROG_DEPTH = TPU_PROG_DEPTH,
    parameter int DATA_W     = 8
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              wr_valid,
    input  logic [DATA_W-1:0]                 wr_data,
    output logic                              wr_ready,
    input  logic                              send,
    output logic                              fetch_ins,
    output logic [DATA_W-1:0]                 ui_out,
    output logic                              busy,
    output logic                              done,
    output logic [$clog2(PROG_DEPTH+1)-1:0]   count
);

    localparam int CW = $clog2(PROG_DEPTH + 1);
    localparam int AW = (PROG_DEPTH > 1) ? $clog2(PROG_DEPTH) : 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(PROG_DEPTH);

    stream_state_t     state, next_state;
    logic [CW-1:0]     idx;
    logic [CW-1:0]     rd_idx;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] byte_sel;
    logic [DATA_W-1:0] ui_next;
    logic              wr_en;

    instr_buffer #(
        .DEPTH  (PROG_DEPTH),
        .DATA_W (DATA_W),
        .AW     (AW)
    ) u_buf (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (count[AW-1:0]),
        .wr_data (wr_data),
        .rd_addr (rd_idx[AW-1:0]),
        .rd_data (rd_data)
    );

    assign wr_ready = (state == LOAD) && (count < DEPTH_C);
    assign wr_en    = (state == LOAD) && wr_valid && wr_ready;

    // idx holds the next byte to present; ARM presents byte 0 directly.
    assign rd_idx   = (state == ARM) ? '0 : idx;
    assign byte_sel = (rd_idx < count) ? rd_data : DATA_W'(OP_NO_OP);

    always_comb begin
        next_state = state;
        ui_next    = DATA_W'(OP_NO_OP);
        case (state)
            LOAD: begin
                if (send) next_state = ARM;
            end
            ARM: begin
                ui_next    = byte_sel;
                next_state = STREAM;
            end
            STREAM: begin
                if (idx == DEPTH_C) begin
                    next_state = DONE;
                end else begin
                    ui_next = byte_sel;
                end
            end
            DONE: begin
                next_state = DONE;
            end
            default: next_state = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LOAD;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count     <= '0;
            idx       <= '0;
            fetch_ins <= 1'b0;
            ui_out    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            if (wr_en) count <= count + 1'b1;
            if (state == ARM) begin
                idx <= CW'(1);
            end else if (state == STREAM && idx != DEPTH_C) begin
                idx <= idx + 1'b1;
            end
            fetch_ins <= (next_state == ARM);
            busy      <= (next_state == ARM) || (next_state == STREAM);
            done      <= (next_state == DONE);
            ui_out    <= ui_next;
        end
    end

endmodule
